// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl_pkg
// Description : Shared types and helpers for the parametrised scratch RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Byte-lane merge: the storage is built lane by lane, so this works per byte.
  function automatic logic [7:0] merge_be(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_byte_array
// Description : Single-port byte-lane storage with registered, gated read.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_byte_array
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_rd_en,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd;
    logic [7:0] w_old;
    logic [7:0] w_new;

    assign w_old = r_mem[i_addr];
    assign w_new = merge_be(w_old, i_wdata[gi*8 +: 8], i_we & i_be[gi]);

    always_ff @(posedge clk) begin
      if (i_we) begin
        r_mem[i_addr] <= w_new;
      end
    end

    // The read register only moves on a response so the output holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd <= '0;
      end else if (i_rd_en) begin
        r_rd <= (RDW_MODE == RDW_NEW) ? w_new : w_old;
      end
    end

    assign o_rdata[gi*8 +: 8] = r_rd;
  end

endmodule
`default_nettype wire

// File: rtl/param_sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : param_sp_ram_ctrl
// Description : Scratch RAM controller: clear sweep FSM, request port, responses.
// Revision    : 1.0 - initial release
// ============================================================================
module param_sp_ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter int                OUT_REG  = 0,
  parameter int                RDW_MODE = 0,
  parameter int                WR_RSP   = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W/8-1:0] i_req_be,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_busy
);

  localparam int  BE_W     = DATA_W / 8;
  localparam bit  C_WR_RSP = (WR_RSP != 0);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_vld1;

  logic                w_acc;
  logic                w_rd_en;
  logic                w_mem_we;
  logic [BE_W-1:0]     w_mem_be;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_arr_rdata;

  assign w_acc   = i_req_valid & r_req_ready;
  assign w_rd_en = w_acc & (~i_req_we | C_WR_RSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (i_clr) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // The sweep owns the port while clearing; requests cannot be accepted then.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_be    = '0;
    w_mem_addr  = i_req_addr;
    w_mem_wdata = i_req_wdata;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_be    = '1;
      w_mem_addr  = r_clr_cnt;
      w_mem_wdata = CLR_VAL;
    end else begin
      w_mem_we    = w_acc & i_req_we;
      w_mem_be    = i_req_be;
    end
  end

  ram_byte_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RDW_MODE (RDW_MODE)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_be    (w_mem_be),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .i_rd_en (w_rd_en),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1 <= 1'b0;
    end else begin
      r_vld1 <= w_rd_en;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              r_vld2;
    logic [DATA_W-1:0] r_out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld2 <= 1'b0;
        r_out  <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) begin
          r_out <= w_arr_rdata;
        end
      end
    end

    assign o_rsp_valid = r_vld2;
    assign o_rsp_rdata = r_out;
  end else begin : g_no_out_reg
    assign o_rsp_valid = r_vld1;
    assign o_rsp_rdata = w_arr_rdata;
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_param_sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sp_ram_ctrl
// Description : Scoreboard bench driving three controller configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sp_ram_ctrl;

  localparam int          NDUT   = 3;
  localparam int          LAT[3] = '{1, 2, 1};
  localparam bit          WRR[3] = '{1'b1, 1'b1, 1'b0};
  localparam bit          RDW[3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [31:0] CV[3]  = '{32'h0000_0000, 32'h5A5A_0F0F, 32'hC3C3_C3C3};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        req_valid;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_v [NDUT];
  logic [31:0] rsp_d [NDUT];
  logic        rdy   [NDUT];
  logic        bsy   [NDUT];

  always #5 clk = ~clk;

  param_sp_ram_ctrl #(.OUT_REG(0), .RDW_MODE(0), .WR_RSP(1), .CLR_VAL(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_req_valid(req_valid), .o_req_ready(rdy[0]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_be(req_be), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_v[0]), .o_rsp_rdata(rsp_d[0]), .o_busy(bsy[0]));
  param_sp_ram_ctrl #(.OUT_REG(1), .RDW_MODE(1), .WR_RSP(1), .CLR_VAL(32'h5A5A_0F0F)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_req_valid(req_valid), .o_req_ready(rdy[1]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_be(req_be), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_v[1]), .o_rsp_rdata(rsp_d[1]), .o_busy(bsy[1]));
  param_sp_ram_ctrl #(.OUT_REG(0), .RDW_MODE(0), .WR_RSP(0), .CLR_VAL(32'hC3C3_C3C3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_req_valid(req_valid), .o_req_ready(rdy[2]),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_be(req_be), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_v[2]), .o_rsp_rdata(rsp_d[2]), .o_busy(bsy[2]));

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic [31:0] mdl  [NDUT][64];
  exp_t        q    [NDUT][$];
  logic [31:0] last [NDUT];
  int          cyc         = 0;
  bit          in_reset    = 1'b1;
  int          sweep_start = 0;
  int          n_chk       = 0;
  int          n_fail      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit mdl_busy();
    return in_reset || (cyc >= sweep_start && cyc < sweep_start + 64);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic fill_model();
    for (int i = 0; i < NDUT; i++)
      for (int w = 0; w < 64; w++) mdl[i][w] = CV[i];
  endtask

  task automatic drive(input bit v, input bit we, input logic [5:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit c);
    bit   idle;
    exp_t e;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_be = b; req_wdata = d; clr = c;
    idle = !mdl_busy();
    if (v && idle) begin
      for (int i = 0; i < NDUT; i++) begin
        logic [31:0] old, nw;
        old = mdl[i][a];
        nw  = merge(old, d, b);
        if (we) mdl[i][a] = nw;
        if (!we || WRR[i]) begin
          e.d   = (we && RDW[i]) ? nw : old;
          e.due = cyc + LAT[i];
          q[i].push_back(e);
        end
      end
    end
    if (c && idle) begin
      sweep_start = cyc + 1;
      fill_model();
    end
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 1'b0, 6'd0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (mdl_busy() && k < 200) begin
      idle_n(1);
      k++;
    end
  endtask

  task automatic rd(input logic [5:0] a);
    drive(1'b1, 1'b0, a, 4'hF, $urandom, 1'b0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] b, input logic [31:0] d);
    drive(1'b1, 1'b1, a, b, d, 1'b0);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; clr = 1'b0; in_reset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      q[i].delete();
      last[i] = '0;
    end
    repeat (n) @(negedge clk);
    rst_n = 1'b1; in_reset = 1'b0; sweep_start = cyc;
    fill_model();
  endtask

  // Monitor: pops the scoreboard whenever a response appears.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NDUT; i++) begin
        bit eb;
        eb = mdl_busy();
        chk("busy", i, 32'(bsy[i]), 32'(eb));
        chk("req_ready", i, 32'(rdy[i]), 32'(!eb));
        if (rsp_v[i] === 1'b1) begin
          if (q[i].size() == 0) begin
            chk("rsp_spurious", i, 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            chk("rsp_data", i, rsp_d[i], e.d);
            chk("rsp_cycle", i, 32'(cyc), 32'(e.due));
            last[i] = e.d;
          end
        end else begin
          chk("rsp_valid_low_or_hold", i, rsp_d[i], last[i]);
          if (q[i].size() != 0 && q[i][0].due <= cyc) begin
            chk("rsp_missing", i, 32'd0, 32'd1);
            void'(q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_be = '0; req_wdata = '0;
    for (int i = 0; i < NDUT; i++) last[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; in_reset = 1'b0; sweep_start = cyc;
    fill_model();

    // Requests offered during the sweep must be ignored.
    repeat (5) wr(6'd1, 4'hF, 32'hBAD0_BAD0);
    wait_idle();
    rd(6'd5);
    wr(6'd3, 4'b0101, 32'hA5A5_A5A5);
    rd(6'd3);
    wr(6'd7, 4'hF, 32'h1122_3344);
    wr(6'd7, 4'hF, 32'hFFFF_FFFF);
    rd(6'd7);
    wr(6'd0, 4'hF, 32'h0102_0304);
    wr(6'd1, 4'hF, 32'h1112_1314);
    wr(6'd2, 4'hF, 32'h2122_2324);
    rd(6'd0); rd(6'd1); rd(6'd2);
    wr(6'd4, 4'hF, 32'h7654_3210);
    wr(6'd4, 4'b0000, 32'hFFFF_FFFF);
    rd(6'd4);
    wr(6'd63, 4'b1000, 32'hEE00_0000);
    rd(6'd63);
    wr(6'd9, 4'hF, 32'hDEAD_BEEF);
    idle_n(2);
    drive(1'b1, 1'b0, 6'd9, 4'hF, 32'd0, 1'b1);
    idle_n(3);
    drive(1'b0, 1'b0, 6'd0, 4'd0, 32'd0, 1'b1);
    wait_idle();
    rd(6'd9);
    idle_n(2);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            6'($urandom_range(0, 15)), 4'($urandom), $urandom,
            $urandom_range(0, 79) == 0);
    end
    wait_idle();

    drive(1'b0, 1'b0, 6'd0, 4'd0, 32'd0, 1'b1);
    idle_n(10);
    pulse_reset(2);
    wait_idle();
    for (int a = 0; a < 4; a++) rd(6'(a));
    for (int n = 0; n < 60; n++)
      drive(1'b1, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), 4'($urandom), $urandom, 1'b0);

    idle_n(4);
    for (int i = 0; i < NDUT; i++) chk("drain", i, 32'(q[i].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
